// File: rtl/ram.sv
// Single-port 32-word synchronous RAM with registered read data and synchronous clear.
// Write-edge output is read-first by default; define RAM_WRITE_THROUGH_EN for write-first.
module ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ram_ena,
  input  logic                  wena,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  // addr is only used as an index while the port is enabled, so an unknown
  // address on an idle port cannot disturb memory or the output register.
  always_comb begin
    mem_d      = mem_q;
    data_out_d = data_out_q;
    if (ram_ena) begin
      if (wena) begin
        mem_d[addr] = data_in;
`ifdef RAM_WRITE_THROUGH_EN
        data_out_d  = data_in;
`else
        data_out_d  = mem_q[addr];
`endif
      end else begin
        data_out_d = mem_q[addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      data_out_q <= data_out_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram: reset, read/write, enable gating,
// read-first/write-first output, reset priority and a full 32-word sweep.
module tb_ram;

  logic        clk;
  logic        rst_n;
  logic        ram_ena;
  logic        wena;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int unsigned n_tests;
  int unsigned n_fail;

  ram #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ram_ena (ram_ena),
    .wena    (wena),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one access, take one edge, leave 1 time unit before sampling.
  task automatic step(input logic rn, input logic en, input logic we,
                      input logic [4:0] a, input logic [31:0] d);
    rst_n   = rn;
    ram_ena = en;
    wena    = we;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wr_out(input logic [31:0] old_v, input logic [31:0] new_v);
`ifdef RAM_WRITE_THROUGH_EN
    return new_v;
`else
    return old_v;
`endif
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    ram_ena = 1'b0;
    wena    = 1'b0;
    addr    = '0;
    data_in = '0;
    #2;

    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check("reset_dout", data_out, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    check("read_after_reset", data_out, 32'd0);

    step(1'b1, 1'b1, 1'b1, 5'd2, 32'd10);
    check("write2_dout", data_out, wr_out(32'd0, 32'd10));
    step(1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    check("read2", data_out, 32'd10);

    step(1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF);
    check("write31_dout", data_out, wr_out(32'd0, 32'hFFFF_FFFF));
    step(1'b1, 1'b1, 1'b1, 5'd0, 32'hA5A5_A5A5);
    check("write0_dout", data_out, wr_out(32'd0, 32'hA5A5_A5A5));
    step(1'b1, 1'b1, 1'b0, 5'd31, 32'd0);
    check("read31", data_out, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    check("read2_noalias", data_out, 32'd10);
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    check("read0", data_out, 32'hA5A5_A5A5);

    step(1'b1, 1'b0, 1'b1, 5'd2, 32'd77);
    check("disabled_hold", data_out, 32'hA5A5_A5A5);
    step(1'b1, 1'b0, 1'b1, 5'bx, 32'd88);
    check("disabled_xaddr_hold", data_out, 32'hA5A5_A5A5);
    step(1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    check("mem2_unchanged", data_out, 32'd10);
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    check("mem0_unchanged", data_out, 32'hA5A5_A5A5);

    step(1'b1, 1'b1, 1'b1, 5'd2, 32'h55);
    check("overwrite2_dout", data_out, wr_out(32'd10, 32'h55));
    step(1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    check("read2_new", data_out, 32'h55);

    step(1'b0, 1'b1, 1'b1, 5'd2, 32'd99);
    check("reset_over_write", data_out, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd2, 32'd0);
    check("read2_cleared", data_out, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd31, 32'd0);
    check("read31_cleared", data_out, 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    check("read0_cleared", data_out, 32'd0);

    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 1'b1, 5'(i), 32'(i * 3));
      check($sformatf("sweep_wr%0d", i), data_out, wr_out(32'd0, 32'(i * 3)));
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'(i), 32'd0);
      check($sformatf("sweep_rd%0d", i), data_out, 32'(i * 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width; only the default value is required to work.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; depth = 2**ADDR_WIDTH = 32 words.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 ram_ena  input  1  SHALL be the port enable; when 0, no access occurs.
REQ-006 wena  input  1  SHALL select write (1) or read (0) when ram_ena=1.
REQ-007 addr  input  ADDR_WIDTH  SHALL be the word address, 0..31.
REQ-008 data_in  input  DATA_WIDTH  SHALL be the write data.
REQ-009 data_out  output  DATA_WIDTH  SHALL be the registered read data.

Function
REQ-010 Storage SHALL be 32 words of DATA_WIDTH bits, single port.
REQ-011 Write: at a rising edge with rst_n=1, ram_ena=1, wena=1, mem[addr] SHALL take data_in.
REQ-012 Read: at a rising edge with rst_n=1, ram_ena=1, wena=0, data_out SHALL take mem[addr]; latency is one clock edge.
REQ-013 During a write edge, data_out SHALL take the pre-write content of mem[addr] (read-first), unless RAM_WRITE_THROUGH_EN is defined.
REQ-014 With ram_ena=0, memory and data_out SHALL hold; wena, addr and data_in are ignored.
REQ-015 Every address 0..31 SHALL be valid; there is no out-of-range case and no wrap-around.
REQ-016 Back-to-back accesses SHALL be supported every cycle, with no stall and no handshake.
REQ-017 Write-then-read of the same address on consecutive edges SHALL return the newly written value.
REQ-018 X or Z on addr while ram_ena=0 SHALL NOT corrupt any state.

Reset
REQ-019 When rst_n=0 at a rising edge, data_out SHALL become 0 and all 32 memory words SHALL become 0 on that edge.
REQ-020 Reset SHALL have priority over ram_ena and wena; a write presented during reset is discarded.
REQ-021 On the first edge after rst_n returns to 1, normal operation SHALL apply.
REQ-022 Before the first reset edge, memory and data_out contents are undefined.

Configuration
REQ-023 Macro RAM_WRITE_THROUGH_EN SHALL control write-edge output behaviour.
- Defined: on a write edge, data_out SHALL take data_in (write-first).
- Undefined: on a write edge, data_out SHALL take the old mem[addr] (read-first).
- Either way, memory write behaviour is identical.

Verification
REQ-024 rst_n=0 for one edge, then ram_ena=1, wena=0, addr=2 -> data_out=0 after the next edge.
REQ-025 ram_ena=1, wena=1, addr=2, data_in=10 -> after the edge, data_out=0 (read-first) or 10 (RAM_WRITE_THROUGH_EN); the next read of addr 2 returns 10.
REQ-026 Write addr 31=0xFFFFFFFF and addr 0=0xA5A5A5A5, then read both -> the correct values are returned, with no aliasing.
REQ-027 ram_ena=0, wena=1, addr=2, data_in=77 -> mem[2] stays 10 and data_out holds its prior value.
REQ-028 After writing addr 2=10, apply rst_n=0 for one edge, then read addr 2 -> data_out=0.
REQ-029 Write addrs 0..31 with value addr*3 on consecutive edges, then read all 32 words back-to-back -> each read returns addr*3 with 1-cycle latency.
